// File: rtl/multiple_retire_packer.sv
// Regroups a stream of single retired uops into NrRetiredInstr-wide commit bundles.
// Accumulator (p0) collects lanes; output register (p1) holds a closed bundle for the consumer.
package mure_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned PRIV_LEN  = 2;
endpackage

module multiple_retire_packer #(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned FlushTimeout   = 8
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic                                                   valid_i,
  output logic                                                   ready_o,
  input  logic                                                   iretire_i,
  input  logic                                                   ilastsize_i,
  input  logic [mure_pkg::ITYPE_LEN-1:0]                         itype_i,
  input  logic [mure_pkg::XLEN-1:0]                              iaddr_i,
  input  logic [mure_pkg::CAUSE_LEN-1:0]                         cause_i,
  input  logic [mure_pkg::XLEN-1:0]                              tval_i,
  input  logic [mure_pkg::PRIV_LEN-1:0]                          priv_i,
  input  logic                                                   flush_i,
  output logic                                                   valid_o,
  input  logic                                                   ready_i,
  output logic [NrRetiredInstr-1:0]                              lane_valid_o,
  output logic [NrRetiredInstr-1:0]                              iretire_o,
  output logic [NrRetiredInstr-1:0]                              ilastsize_o,
  output logic [NrRetiredInstr-1:0][mure_pkg::ITYPE_LEN-1:0]     itype_o,
  output logic [NrRetiredInstr-1:0][mure_pkg::XLEN-1:0]          iaddr_o,
  output logic [mure_pkg::CAUSE_LEN-1:0]                         cause_o,
  output logic [mure_pkg::XLEN-1:0]                              tval_o,
  output logic [mure_pkg::PRIV_LEN-1:0]                          priv_o
);

  localparam int unsigned N  = NrRetiredInstr;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = (FlushTimeout > 0) ? $clog2(FlushTimeout + 1) : 1;

  typedef enum logic {FILLING, PENDING} state_e;

  typedef struct packed {
    logic [N-1:0]                              lv;
    logic [N-1:0]                              iretire;
    logic [N-1:0]                              ilastsize;
    logic [N-1:0][mure_pkg::ITYPE_LEN-1:0]     itype;
    logic [N-1:0][mure_pkg::XLEN-1:0]          iaddr;
    logic [mure_pkg::CAUSE_LEN-1:0]            cause;
    logic [mure_pkg::XLEN-1:0]                 tval;
    logic [mure_pkg::PRIV_LEN-1:0]             priv;
  } bundle_t;

  state_e        state_p0;
  logic [CW-1:0] cnt_p0;
  logic [IW-1:0] idle_p0;
  bundle_t       acc_p0;
  bundle_t       out_p1;
  logic          vld_p1;

  bundle_t       bnd;
  logic          filling, has_fill, priv_mismatch, accept, trap, timeout_hit, close, out_free;
  logic [CW-1:0] cnt_nxt;

  assign filling       = (state_p0 == FILLING);
  assign has_fill      = (cnt_p0 != '0);
  // A privilege change cannot share a bundle: stall the uop and close what is held.
  assign priv_mismatch = filling && valid_i && has_fill && (priv_i != acc_p0.priv);
  assign ready_o       = rst_ni && filling && !priv_mismatch;
  assign accept        = valid_i && ready_o;
  assign cnt_nxt       = cnt_p0 + CW'(accept);
  assign trap          = (itype_i == mure_pkg::ITYPE_LEN'(1)) || (itype_i == mure_pkg::ITYPE_LEN'(2));
  // The idle cycle that brings the count to FlushTimeout is the closing cycle.
  assign timeout_hit   = (FlushTimeout != 0) && ((int'(idle_p0) + 1) >= int'(FlushTimeout));
  assign close         = filling && (accept ? ((cnt_nxt == CW'(N)) || trap || flush_i)
                                            : (has_fill && (flush_i || timeout_hit || priv_mismatch)));
  assign out_free      = !vld_p1 || ready_i;

  always_comb begin
    bnd = acc_p0;
    if (accept) begin
      for (int i = 0; i < int'(N); i++) begin
        if (cnt_p0 == CW'(i)) begin
          bnd.lv[i]        = 1'b1;
          bnd.iretire[i]   = iretire_i;
          bnd.ilastsize[i] = ilastsize_i;
          bnd.itype[i]     = itype_i;
          bnd.iaddr[i]     = iaddr_i;
        end
      end
      bnd.cause = cause_i;
      bnd.tval  = tval_i;
      if (!has_fill) bnd.priv = priv_i;
    end
  end

  // Stage p0 (accumulator) -> stage p1 (output register)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_p0 <= FILLING;
      cnt_p0   <= '0;
      idle_p0  <= '0;
      acc_p0   <= '0;
      out_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (vld_p1 && ready_i) vld_p1 <= 1'b0;

      if (accept || close) begin
        idle_p0 <= '0;
      end else if (filling && has_fill && (int'(idle_p0) < int'(FlushTimeout))) begin
        idle_p0 <= idle_p0 + IW'(1);
      end

      case (state_p0)
        FILLING: begin
          if (close && out_free) begin
            out_p1 <= bnd;
            vld_p1 <= 1'b1;
            acc_p0 <= '0;
            cnt_p0 <= '0;
          end else begin
            acc_p0 <= bnd;
            cnt_p0 <= cnt_nxt;
            if (close) state_p0 <= PENDING;
          end
        end
        PENDING: begin
          if (out_free) begin
            out_p1   <= acc_p0;
            vld_p1   <= 1'b1;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            state_p0 <= FILLING;
          end
        end
        default: state_p0 <= FILLING;
      endcase
    end
  end

  assign valid_o      = vld_p1;
  assign lane_valid_o = out_p1.lv;
  assign iretire_o    = out_p1.iretire;
  assign ilastsize_o  = out_p1.ilastsize;
  assign itype_o      = out_p1.itype;
  assign iaddr_o      = out_p1.iaddr;
  assign cause_o      = out_p1.cause;
  assign tval_o       = out_p1.tval;
  assign priv_o       = out_p1.priv;

endmodule

// File: doc/multiple_retire_packer.md
Name: multiple_retire_packer

Overview:
- Inverse of the multi-retirement serializer: accepts one retired uop per cycle and regroups consecutive uops into NrRetiredInstr-wide commit bundles.
- Each bundle carries a per-lane valid mask plus common cause/tval/priv.
- Used as a trace-path loopback and as an adapter feeding wide-commit consumers from single-issue trace sources.
- Uses a double-buffered datapath: accumulator plus output register, with valid/ready on both sides.

Parameters:
- NrRetiredInstr, 2, number of lanes per bundle (≥2).
- FlushTimeout, 8, idle cycles before a partial bundle is closed; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  1  input uop valid
- ready_o  out  1  input uop accepted when valid_i&&ready_o
- iretire_i  in  1  uop retire flag
- ilastsize_i  in  1  uop last-size flag
- itype_i  in  mure_pkg::ITYPE_LEN  uop itype
- iaddr_i  in  mure_pkg::XLEN  uop address
- cause_i  in  mure_pkg::CAUSE_LEN  trap cause
- tval_i  in  mure_pkg::XLEN  trap value
- priv_i  in  mure_pkg::PRIV_LEN  privilege level
- flush_i  in  1  force close of partial bundle
- valid_o  out  1  bundle valid
- ready_i  in  1  bundle consumed when valid_o&&ready_i
- lane_valid_o  out  NrRetiredInstr  filled-lane mask
- iretire_o  out  NrRetiredInstr  per-lane iretire
- ilastsize_o  out  NrRetiredInstr  per-lane ilastsize
- itype_o  out  [NrRetiredInstr][ITYPE_LEN]  per-lane itype
- iaddr_o  out  [NrRetiredInstr][XLEN]  per-lane address
- cause_o  out  CAUSE_LEN  bundle cause
- tval_o  out  XLEN  bundle tval
- priv_o  out  PRIV_LEN  bundle priv

Behaviour:
- Reset: all outputs and registers are 0; accumulator state is FILLING with cnt=0 and idle_cnt=0. ready_o is combinational and equals 1 once out of reset.
- Accumulator states:
  - FILLING: ready_o=1, except in the priv-mismatch case below.
  - PENDING: a closed bundle waits for the output register; ready_o=0.
- Lane fill: an accepted uop is written into lane cnt, and cnt increments. Lanes are always filled in order 0..cnt-1.
- Priv capture: priv is latched from the lane-0 uop. cause/tval are latched from every accepted uop, so the bundle carries the last accepted values.
- Close triggers (evaluated on the accept cycle or the idle cycle):
  - (a) cnt reaches NrRetiredInstr;
  - (b) the accepted uop has itype 1 (exception) or 2 (interrupt);
  - (c) flush_i=1 with a nonzero resulting fill;
  - (d) idle_cnt==FlushTimeout with cnt>0 and FlushTimeout≠0.
- Priv mismatch: valid_i=1 with priv_i≠latched priv while cnt>0 forces ready_o=0 and closes the current bundle that cycle. The uop is accepted the following cycle into an empty accumulator.
- flush_i together with an accepted uop: the uop is included, then the bundle closes. flush_i with cnt=0 and no accept is a no-op.
- Output register free condition: out_free = !valid_o || ready_i.
- On close:
  - If out_free, the bundle moves to the output register at the same edge, valid_o=1 the next cycle, and the accumulator is cleared (cnt=0, lanes zero).
  - Otherwise the state goes to PENDING, and the transfer happens on the first cycle out_free=1, then back to FILLING.
- Latency: 1 cycle from the closing event to valid_o.
- Output register: lanes ≥ fill count are zero, with lane_valid_o bit clear. The register is held stable while valid_o&&!ready_i. valid_o drops after consumption if no new transfer occurs.
- idle_cnt:
  - increments each cycle in FILLING with cnt>0 and no accept;
  - resets to 0 on accept or close;
  - saturates at FlushTimeout.
- Throughput: with ready_i=1, one uop per cycle is sustained and no bubbles are inserted.
- Reset mid-operation: discards the accumulator and output register immediately (asynchronous); there is no partial emission afterwards.

Test Plan:
- Full bundles: NrRetiredInstr=2, 4 uops with addrs 0x100/0x104/0x108/0x10C, itype=0, ready_i=1.
  - Required: two bundles with lane_valid_o=2'b11, iaddr_o={0x104,0x100} then {0x10C,0x108}, each valid_o one cycle after its 2nd lane is accepted.
- Exception close: uop0 itype=1, cause=2, tval=0xDEAD.
  - Required: bundle lane_valid_o=2'b01, cause_o=2, tval_o=0xDEAD, lane1 all zero.
- Backpressure: ready_i=0, stream 6 uops.
  - Required: 4 accepted (2 in output register, 2 PENDING), then ready_o=0.
  - On ready_i=1, bundles emerge in order with no loss; ready_o returns to 1 the cycle after PENDING transfers.
- Priv change: uop0 priv=3, uop1 priv=0.
  - Required: ready_o=0 for one cycle; bundle A lane_valid_o=01 with priv_o=3.
  - uop1 is accepted next cycle and starts bundle B with priv_o=0.
- Timeout: FlushTimeout=4, one uop accepted at cycle t, then idle.
  - Required: close at t+4, valid_o=1 at t+5 with lane_valid_o=01.
  - flush_i at t+1 instead gives valid_o at t+2.
- Reset mid-bundle: assert rst_ni=0 with cnt=1 and valid_o=1.
  - Required: all outputs 0 immediately, ready_o=1 after release, and the next bundle contains only post-reset uops.
